// File: rtl/vga_pkg.sv
// Shared VGA rendering types and constants.
//   rgb12_t       : packed {r,g,b} 4 bits each
//   GRID_LINE_RGB : lattice colour drawn when GRID_LINES_EN is defined
//   BLACK_RGB     : blanking colour
//   RENDER_LAT    : input-sample to colour-output latency in pixel clocks
package vga_pkg;

  localparam int unsigned RENDER_LAT = 2;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  localparam rgb12_t GRID_LINE_RGB = rgb12_t'(12'h444);
  localparam rgb12_t BLACK_RGB     = rgb12_t'(12'h000);

endpackage

// File: rtl/cell_axis_counter.sv
// One axis of the cell walker: a sub-cell counter (0..CELL-1) and a cell
// index that steps on each sub-counter wrap and saturates at CELLS.
//   clk_i, rst_ni : clock, async active-low reset
//   clr_i         : synchronous clear of both counters (wins over adv_i)
//   adv_i         : advance by one pixel/line
//   sub_o         : position inside the current cell
//   idx_o         : cell index, CELLS means "past the grid"
module cell_axis_counter #(
  parameter int unsigned CELL  = 20,
  parameter int unsigned CELLS = 32,
  localparam int unsigned SUB_W = $clog2(CELL),
  localparam int unsigned IDX_W = $clog2(CELLS + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             adv_i,
  output logic [SUB_W-1:0] sub_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [SUB_W-1:0] sub_q, sub_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Next-state: clear, or step sub-counter and carry into the saturating index.
  always_comb begin
    sub_d = sub_q;
    idx_d = idx_q;
    if (clr_i) begin
      sub_d = '0;
      idx_d = '0;
    end else if (adv_i) begin
      if (sub_q == SUB_W'(CELL - 1)) begin
        sub_d = '0;
        if (idx_q != IDX_W'(CELLS)) idx_d = idx_q + IDX_W'(1);
      end else begin
        sub_d = sub_q + SUB_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sub_q <= '0;
      idx_q <= '0;
    end else begin
      sub_q <= sub_d;
      idx_q <= idx_d;
    end
  end

  assign sub_o = sub_q;
  assign idx_o = idx_q;

endmodule

// File: rtl/grid_pixel_renderer.sv
// Renders the Game-of-Life cell grid as 12-bit VGA colour, two pixel clocks
// behind the sync generator, reading cells through a synchronous RAM port.
// Optional build macro: GRID_LINES_EN draws a 1-pixel lattice (GRID_LINE_RGB)
// on the first column and first line of every cell.
//   i_clk, i_rst_n           : pixel clock, async active-low reset
//   i_hsync_n, i_vsync_n     : syncs in; o_hsync_n/o_vsync_n delayed RENDER_LAT
//   i_hblank_n, i_vblank_n   : high during active pixels / active lines
//   o_cell_addr, i_cell_data : row*GRID_W+col read address; data one cycle later
//   i_alive_rgb, i_dead_rgb, i_border_rgb : colour selection inputs
//   o_vga_r/g/b              : registered colour
//   o_frame_start            : one-cycle pulse at start of vertical blanking
module grid_pixel_renderer
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned CELL_W   = 20,
  parameter int unsigned CELL_H   = 20,
  parameter int unsigned GRID_W   = 32,
  parameter int unsigned GRID_H   = 24
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic                                i_hsync_n,
  input  logic                                i_vsync_n,
  input  logic                                i_hblank_n,
  input  logic                                i_vblank_n,
  output logic [$clog2(GRID_W*GRID_H)-1:0]    o_cell_addr,
  input  logic                                i_cell_data,
  input  logic [11:0]                         i_alive_rgb,
  input  logic [11:0]                         i_dead_rgb,
  input  logic [11:0]                         i_border_rgb,
  output logic [3:0]                          o_vga_r,
  output logic [3:0]                          o_vga_g,
  output logic [3:0]                          o_vga_b,
  output logic                                o_hsync_n,
  output logic                                o_vsync_n,
  output logic                                o_frame_start
);

  localparam int unsigned ADDR_W   = $clog2(GRID_W * GRID_H);
  localparam int unsigned COL_W    = $clog2(GRID_W + 1);
  localparam int unsigned ROW_W    = $clog2(GRID_H + 1);
  localparam int unsigned SUBX_W   = $clog2(CELL_W);
  localparam int unsigned SUBY_W   = $clog2(CELL_H);
  // Cells that can appear on screen; anything beyond is never addressed.
  localparam int unsigned SCR_COLS = (H_ACTIVE + CELL_W - 1) / CELL_W;
  localparam int unsigned SCR_ROWS = (V_ACTIVE + CELL_H - 1) / CELL_H;
  localparam int unsigned VIS_COLS = (SCR_COLS < GRID_W) ? SCR_COLS : GRID_W;
  localparam int unsigned VIS_ROWS = (SCR_ROWS < GRID_H) ? SCR_ROWS : GRID_H;

  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;

  logic [0:0] state_q, state_d;
  logic       locked_c;
  logic       hblank_q, vblank_q;
  logic       x_clr_c, x_adv_c, y_clr_c, y_adv_c;
  logic [SUBX_W-1:0] sub_x;
  logic [SUBY_W-1:0] sub_y;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic       in_grid_c, active_c;
  logic       active_q1, in_grid_q1;
  logic [RENDER_LAT-1:0] hs_pipe_q, vs_pipe_q;
  rgb12_t     rgb_q, rgb_d;
  logic       frame_start_d, frame_start_q;

  // Lock FSM: wait for a vertical blank so output always starts on a frame.
  always_comb begin
    state_d = state_q;
    if (state_q == ST_UNLOCKED && !i_vblank_n) state_d = ST_LOCKED;
  end

  assign locked_c = (state_q == ST_LOCKED);

  // Pixel advance inside active area; line advance on the hblank_n falling edge.
  assign x_clr_c = !i_hblank_n || !locked_c;
  assign x_adv_c = i_hblank_n && i_vblank_n && locked_c;
  assign y_clr_c = !i_vblank_n || !locked_c;
  assign y_adv_c = hblank_q && !i_hblank_n && i_vblank_n && locked_c;

  cell_axis_counter #(.CELL(CELL_W), .CELLS(GRID_W)) u_x_cnt (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .clr_i  (x_clr_c),
    .adv_i  (x_adv_c),
    .sub_o  (sub_x),
    .idx_o  (col)
  );

  cell_axis_counter #(.CELL(CELL_H), .CELLS(GRID_H)) u_y_cnt (
    .clk_i  (i_clk),
    .rst_ni (i_rst_n),
    .clr_i  (y_clr_c),
    .adv_i  (y_adv_c),
    .sub_o  (sub_y),
    .idx_o  (row)
  );

  assign in_grid_c   = (col < COL_W'(VIS_COLS)) && (row < ROW_W'(VIS_ROWS));
  assign active_c    = i_hblank_n && i_vblank_n && locked_c;
  assign o_cell_addr = in_grid_c ? (ADDR_W'(row) * ADDR_W'(GRID_W) + ADDR_W'(col))
                                 : '0;

`ifdef GRID_LINES_EN
  logic grid_line_q1;
`else
  logic unused_sub;
  assign unused_sub = ^{sub_x, sub_y};
`endif

  // Colour select for the pixel whose cell data is arriving this cycle.
  always_comb begin
    rgb_d = BLACK_RGB;
    if (!active_q1)          rgb_d = BLACK_RGB;
    else if (!in_grid_q1)    rgb_d = rgb12_t'(i_border_rgb);
`ifdef GRID_LINES_EN
    else if (grid_line_q1)   rgb_d = GRID_LINE_RGB;
`endif
    else if (i_cell_data)    rgb_d = rgb12_t'(i_alive_rgb);
    else                     rgb_d = rgb12_t'(i_dead_rgb);
  end

  assign frame_start_d = vblank_q && !i_vblank_n && locked_c;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_UNLOCKED;
      hblank_q      <= 1'b1;
      vblank_q      <= 1'b1;
      active_q1     <= 1'b0;
      in_grid_q1    <= 1'b0;
      hs_pipe_q     <= '1;
      vs_pipe_q     <= '1;
      rgb_q         <= BLACK_RGB;
      frame_start_q <= 1'b0;
`ifdef GRID_LINES_EN
      grid_line_q1  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      hblank_q      <= i_hblank_n;
      vblank_q      <= i_vblank_n;
      active_q1     <= active_c;
      in_grid_q1    <= in_grid_c;
      hs_pipe_q     <= {hs_pipe_q[RENDER_LAT-2:0], i_hsync_n};
      vs_pipe_q     <= {vs_pipe_q[RENDER_LAT-2:0], i_vsync_n};
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
`ifdef GRID_LINES_EN
      grid_line_q1  <= (sub_x == '0) || (sub_y == '0);
`endif
    end
  end

  assign o_vga_r       = rgb_q.r;
  assign o_vga_g       = rgb_q.g;
  assign o_vga_b       = rgb_q.b;
  assign o_hsync_n     = hs_pipe_q[RENDER_LAT-1];
  assign o_vsync_n     = vs_pipe_q[RENDER_LAT-1];
  assign o_frame_start = frame_start_q;

endmodule

// File: tb/tb_grid_pixel_renderer.sv
// Directed bench for grid_pixel_renderer on a reduced 40x12 screen with an
// 8x5 grid of 4x3 cells (border on the right, rows beyond the screen).
// Expected pixels and syncs are queued per driven cycle and popped when the
// DUT output for that cycle is due; frame_start and addresses are checked too.
module tb_grid_pixel_renderer;

  localparam int H_ACT = 40;
  localparam int V_ACT = 12;
  localparam int CW    = 4;
  localparam int CH    = 3;
  localparam int GW    = 8;
  localparam int GH    = 5;
  localparam int HB    = 10;
  localparam int VB    = 3;
  localparam int AW    = $clog2(GW * GH);
  localparam logic [11:0] LATTICE = 12'h444;

  typedef struct packed {
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } pix_exp_t;

  logic          clk;
  logic          rst_n = 1'b1;
  logic          hsync_n, vsync_n, hblank_n, vblank_n;
  logic [AW-1:0] cell_addr;
  logic          cell_data;
  logic [11:0]   alive_rgb, dead_rgb, border_rgb;
  logic [3:0]    vga_r, vga_g, vga_b;
  logic          o_hs, o_vs, frame_start;

  logic          cells [0:(1<<AW)-1];
  pix_exp_t      pix_q [$];
  bit            fs_q  [$];
  bit            m_locked;
  bit            m_vb_prev;
  int            cmp_cnt;
  int            err_cnt;

  grid_pixel_renderer #(
    .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .CELL_W(CW), .CELL_H(CH),
    .GRID_W(GW), .GRID_H(GH)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_hsync_n    (hsync_n),
    .i_vsync_n    (vsync_n),
    .i_hblank_n   (hblank_n),
    .i_vblank_n   (vblank_n),
    .o_cell_addr  (cell_addr),
    .i_cell_data  (cell_data),
    .i_alive_rgb  (alive_rgb),
    .i_dead_rgb   (dead_rgb),
    .i_border_rgb (border_rgb),
    .o_vga_r      (vga_r),
    .o_vga_g      (vga_g),
    .o_vga_b      (vga_b),
    .o_hsync_n    (o_hs),
    .o_vsync_n    (o_vs),
    .o_frame_start(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous cell RAM: data valid the cycle after the address.
  always @(posedge clk) cell_data <= cells[cell_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp)
    else begin
      err_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One pixel clock: check due outputs, drive inputs, queue expectations.
  task automatic step(input bit rst, input bit hb, input bit vb, input bit hs,
                      input bit vs, input int x, input int y);
    pix_exp_t    e;
    bit          f;
    int          col, row, ea;
    bit          ing;
    logic [11:0] c;
    @(negedge clk);
    if (!rst) begin
      rst_n = 1'b0;
      #1;
      chk("reset_out", {17'd0, vga_r, vga_g, vga_b, o_hs, o_vs, frame_start},
          {17'd0, 12'h000, 1'b1, 1'b1, 1'b0});
      chk("reset_addr", {26'd0, cell_addr}, 32'd0);
      pix_q.delete();
      fs_q.delete();
      m_locked  = 1'b0;
      m_vb_prev = 1'b1;
    end else begin
      rst_n = 1'b1;
      if (pix_q.size() == 2) begin
        e = pix_q.pop_front();
        chk("pixel_rgb", {20'd0, vga_r, vga_g, vga_b}, {20'd0, e.rgb});
        chk("syncs", {30'd0, o_hs, o_vs}, {30'd0, e.hs, e.vs});
      end
      if (fs_q.size() == 1) begin
        f = fs_q.pop_front();
        chk("frame_start", {31'd0, frame_start}, {31'd0, f});
      end
    end
    hblank_n = hb;
    vblank_n = vb;
    hsync_n  = hs;
    vsync_n  = vs;
    if (rst) begin
      col = x / CW;
      row = y / CH;
      ing = (col < GW) && (row < GH);
      ea  = ing ? row * GW + col : 0;
      if (!(m_locked && hb && vb))  c = 12'h000;
      else if (!ing)                c = border_rgb;
`ifdef GRID_LINES_EN
      else if ((x % CW == 0) || (y % CH == 0)) c = LATTICE;
`endif
      else if (cells[ea])           c = alive_rgb;
      else                          c = dead_rgb;
      if (m_locked && hb && vb) chk("cell_addr", {26'd0, cell_addr}, 32'(ea));
      e.rgb = c;
      e.hs  = hs;
      e.vs  = vs;
      pix_q.push_back(e);
      fs_q.push_back(m_locked && m_vb_prev && !vb);
      m_vb_prev = vb;
      if (!vb) m_locked = 1'b1;
    end
  endtask

  task automatic run_line(input int y, input bit vb, input bit vs, input int xs);
    for (int x = xs; x < H_ACT; x++) step(1'b1, 1'b1, vb, 1'b1, vs, x, y);
    for (int b = 0; b < HB; b++)
      step(1'b1, 1'b0, vb, (b >= 2 && b < 6) ? 1'b0 : 1'b1, vs, 0, y);
  endtask

  task automatic run_frame(input int first_y);
    for (int y = first_y; y < V_ACT; y++) run_line(y, 1'b1, 1'b1, 0);
    for (int v = 0; v < VB; v++) run_line(0, 1'b0, (v == 1) ? 1'b0 : 1'b1, 0);
  endtask

  initial begin
    cmp_cnt    = 0;
    err_cnt    = 0;
    m_locked   = 1'b0;
    m_vb_prev  = 1'b1;
    hblank_n   = 1'b1;
    vblank_n   = 1'b1;
    hsync_n    = 1'b1;
    vsync_n    = 1'b1;
    alive_rgb  = 12'hFFF;
    dead_rgb   = 12'h000;
    border_rgb = 12'h00F;
    for (int i = 0; i < (1 << AW); i++) cells[i] = 1'b0;
    cells[1] = 1'b1;
    #2 rst_n = 1'b0;

    // Reset held mid-line, released mid-line: black until the first vblank.
    for (int x = 10; x < 14; x++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, x, 5);
    run_line(5, 1'b1, 1'b1, 14);
    run_frame(6);

    // Single live cell at column 1, white on black with blue border.
    run_frame(0);

    // Random grid with distinct colours.
    for (int i = 0; i < GW * GH; i++) cells[i] = 1'($urandom_range(0, 1));
    alive_rgb  = 12'h0F0;
    dead_rgb   = 12'h321;
    border_rgb = 12'hA5A;
    run_frame(0);

    // Reset in the middle of a frame: stays black until the next vblank.
    for (int y = 0; y < 5; y++) run_line(y, 1'b1, 1'b1, 0);
    for (int x = 0; x < 15; x++) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, x, 5);
    for (int x = 15; x < 19; x++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, x, 5);
    run_line(5, 1'b1, 1'b1, 19);
    run_frame(6);

    // Checkerboard after relock.
    for (int i = 0; i < GW * GH; i++) cells[i] = 1'(((i / GW) + (i % GW)) % 2);
    alive_rgb  = 12'hC0D;
    dead_rgb   = 12'h1E2;
    border_rgb = 12'h777;
    run_frame(0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
